// File: rtl/ctrl_pkg.sv
// Shared state, instruction-class and ALU-operation encodings for the multi-cycle RV32I sequencer.
// Pure definitions: no latency, no flow control.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } inst_cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  function automatic inst_cls_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps {instruction class, funct7, funct3} to an ALU operation and an illegal-encoding flag.
// Purely combinational, zero latency, no flow control.
module alu_decoder
  import ctrl_pkg::*;
(
  input  inst_cls_t   cls,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic        illegal
);

  // Only funct7[5] (SUB vs ADD) carries meaning for the supported subset.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_op = (cls == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      CLS_LOAD, CLS_STORE: alu_op = ALU_ADD;
      CLS_BRANCH: begin
        alu_op  = ALU_SUB;
        illegal = (funct3[2:1] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving the RV32I datapath strobes.
// Branch 3, ALU 4, store 4+w, load 5+w cycles; MEM stalls on mem_ready and traps after MEM_TIMEOUT cycles.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_control,
  input  logic [9:0]       inst_alu,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             sel,
  output logic             sel2,
  output logic             regw,
  output logic             alu_src,
  output logic             memw,
  output logic             memr,
  output logic [3:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, nxt_state;
  inst_cls_t         cls, nxt_cls;
  logic [2:0]        funct3, nxt_funct3;
  logic [6:0]        funct7, nxt_funct7;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        dec_op;
  logic              dec_ill;
  logic              pc_en_q;
  logic              store_done;
  logic              timeout;

  // Fields are live from the instruction bus while decoding, latched afterwards.
  always_comb begin
    nxt_cls    = cls;
    nxt_funct3 = funct3;
    nxt_funct7 = funct7;
    if (state == S_DECODE) begin
      nxt_cls    = classify(inst_control);
      nxt_funct3 = inst_alu[2:0];
      nxt_funct7 = inst_alu[9:3];
    end
  end

  alu_decoder u_alu_decoder (
    .cls     (nxt_cls),
    .funct7  (nxt_funct7),
    .funct3  (nxt_funct3),
    .alu_op  (dec_op),
    .illegal (dec_ill)
  );

  assign store_done = (state == S_MEM) && (cls == CLS_STORE) && mem_ready;
  assign timeout    = (state == S_MEM) && !mem_ready &&
                      (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt_state = state;
    case (state)
      S_FETCH:   nxt_state = S_DECODE;
      S_DECODE:  nxt_state = (nxt_cls == CLS_NONE) ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        if (dec_ill) begin
          nxt_state = S_TRAP;
        end else begin
          case (cls)
            CLS_R, CLS_I:        nxt_state = S_WB;
            CLS_LOAD, CLS_STORE: nxt_state = S_MEM;
            default:             nxt_state = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        if (mem_ready)    nxt_state = (cls == CLS_LOAD) ? S_WB : S_FETCH;
        else if (timeout) nxt_state = S_TRAP;
      end
      S_WB:      nxt_state = S_FETCH;
      S_TRAP:    nxt_state = S_TRAP;
      default:   nxt_state = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      cls        <= CLS_NONE;
      funct3     <= '0;
      funct7     <= '0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
      pc_en_q    <= 1'b0;
      regw       <= 1'b0;
      sel2       <= 1'b0;
      memr       <= 1'b0;
      memw       <= 1'b0;
      alu_src    <= 1'b0;
      alu_op     <= '0;
      trap       <= 1'b0;
    end else begin
      state  <= nxt_state;
      cls    <= nxt_cls;
      funct3 <= nxt_funct3;
      funct7 <= nxt_funct7;

      if (state != S_MEM)  wait_cnt <= '0;
      else if (!mem_ready) wait_cnt <= wait_cnt + 1'b1;

      if (pc_en) retire_cnt <= retire_cnt + 1'b1;

      pc_en_q <= (nxt_state == S_WB) ||
                 (nxt_state == S_EXECUTE && nxt_cls == CLS_BRANCH && !dec_ill);
      regw    <= (nxt_state == S_WB);
      sel2    <= (nxt_state == S_WB) && (nxt_cls == CLS_LOAD);
      memr    <= (nxt_state == S_MEM) && (nxt_cls == CLS_LOAD);
      memw    <= (nxt_state == S_MEM) && (nxt_cls == CLS_STORE);
      alu_src <= (nxt_state == S_EXECUTE || nxt_state == S_MEM) &&
                 (nxt_cls inside {CLS_I, CLS_LOAD, CLS_STORE});
      if (nxt_state == S_TRAP)         alu_op <= '0;
      else if (nxt_state == S_EXECUTE) alu_op <= dec_op;
      else                             alu_op <= ALU_ADD;
      trap    <= (nxt_state == S_TRAP);
    end
  end

  assign pc_en = pc_en_q | store_done;
  assign sel   = (state == S_EXECUTE) && (cls == CLS_BRANCH) && !dec_ill &&
                 (funct3[0] ? !zero_flag : zero_flag);

endmodule
